// File: rtl/adc_sample_rx.sv
// adc_sample_rx: deserializes MSB-first serial ADC words into a small FIFO and
// hands them one at a time to the four-sample averager over the modwait
// handshake.
// Optional build macro PARITY_CHECK_EN: frames carry a trailing even-parity
// bit, bad words are dropped and flagged on parity_err.
//
// Output FSM
//   state     | meaning
//   IDLE      | waiting for a FIFO entry; pops the head into sample_data
//   PRESENT   | data_ready high, sample_data held, waiting for modwait=1
//   WAIT_DONE | averager busy, waiting for modwait=0
module adc_sample_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          frame_start,
  input  logic                          bit_en,
  input  logic                          serial_in,
  input  logic                          modwait,
  output logic [DATA_WIDTH-1:0]         sample_data,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun
`ifdef PARITY_CHECK_EN
  ,
  output logic                          parity_err
`endif
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = DATA_WIDTH;
`endif
  localparam int BCNT_W = $clog2(FRAME_LEN + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESENT   = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [FRAME_LEN-1:0]    shift_q, shift_d;
  logic [BCNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   sample_q, sample_d;

  logic                    word_done;
  logic                    parity_ok;
  logic                    push_req;
  logic                    push_ok;
  logic                    pop;
  logic                    full;
  logic [DATA_WIDTH-1:0]   word;

  // A complete frame sits in the shift register for exactly one cycle; the
  // data payload is the top DATA_WIDTH bits (parity, if any, is the LSB).
  assign word_done = (bit_cnt_q == BCNT_W'(FRAME_LEN));
  assign word      = shift_q[FRAME_LEN-1 -: DATA_WIDTH];
`ifdef PARITY_CHECK_EN
  assign parity_ok  = ~(^shift_q);
  assign parity_err = word_done && !parity_ok;
`else
  assign parity_ok  = 1'b1;
`endif

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign push_req = word_done && parity_ok;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push_req && (!full || pop);
  assign overrun  = push_req && full && !pop;

  assign data_ready  = (state_q == PRESENT);
  assign sample_data = sample_q;
  assign fifo_count  = count_q;

  // Serial assembler: frame_start or a finished word restarts the count, and
  // a bit arriving in that same cycle becomes bit 0 of the next word.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (bit_en) begin
      shift_d = {shift_q[FRAME_LEN-2:0], serial_in};
    end
    if (frame_start || word_done) begin
      bit_cnt_d = bit_en ? BCNT_W'(1) : '0;
    end else if (bit_en) begin
      bit_cnt_d = bit_cnt_q + BCNT_W'(1);
    end
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output handshake FSM; sample_q only changes on a pop.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          sample_d = mem_q[rd_ptr_q];
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (modwait) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!modwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sample_q  <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sample_q  <= sample_d;
    end
  end

endmodule
